// File: rtl/pc_seq_ctrl.sv
// Multicycle fetch/decode sequencer for PC-changing instructions; other opcodes go to the execute controller.
// Optional: define PC_SEQ_BRANCH_EXT_EN to decode ble (0x06) and bgt (0x07) as branches.
module pc_seq_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       exec_done,
  output logic       mem_read,
  output logic       ir_write,
  output logic       pc_write,
  output logic       eq_c,
  output logic       ne_c,
  output logic       gt_c,
  output logic       lte_c,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       aluout_write,
  output logic       reg_write_ra,
  output logic       sp_init,
  output logic       exec_req
);

  typedef enum logic [3:0] {
    RESET_ST = 4'd0,
    FETCH    = 4'd1,
    IR_LOAD  = 4'd2,
    DECODE   = 4'd3,
    BRANCH   = 4'd4,
    JUMP     = 4'd5,
    JAL      = 4'd6,
    JR       = 4'd7,
    HANDOFF  = 4'd8
  } state_e;

  typedef struct packed {
    logic       mem_read;
    logic       ir_write;
    logic       pc_write;
    logic       eq_c;
    logic       ne_c;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       aluout_write;
    logic       reg_write_ra;
    logic       sp_init;
    logic       exec_req;
  } ctrl_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] FN_JR     = 6'h08;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       is_branch;

`ifdef PC_SEQ_BRANCH_EXT_EN
  localparam logic [5:0] OP_BLE = 6'h06;
  localparam logic [5:0] OP_BGT = 6'h07;
  logic gt_q, lte_q;
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                     (opcode == OP_BLE) || (opcode == OP_BGT);
`else
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
`endif

  // Output image of a state; opcode only matters for the BRANCH selects,
  // and it is stable from DECODE onward, so decoding it on BRANCH entry is safe.
  function automatic ctrl_t decode_ctrl(input state_e s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      RESET_ST: c.sp_init = 1'b1;
      FETCH:    c.mem_read = 1'b1;
      IR_LOAD: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_source = 2'b00;
        c.alu_src_a = 1'b0;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      DECODE: begin
        c.alu_src_a    = 1'b0;
        c.alu_src_b    = 2'b11;
        c.alu_op       = ALU_ADD;
        c.aluout_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = ALU_SUB;
        c.pc_source = 2'b01;
        c.eq_c      = (op == OP_BEQ);
        c.ne_c      = (op == OP_BNE);
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      JAL: begin
        c.reg_write_ra = 1'b1;
        c.pc_write     = 1'b1;
        c.pc_source    = 2'b10;
      end
      JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b11;
      end
      HANDOFF:  c.exec_req = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RESET_ST: begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = IR_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      IR_LOAD: state_d = DECODE;
      DECODE: begin
        if (is_branch)                                   state_d = BRANCH;
        else if (opcode == OP_J)                         state_d = JUMP;
        else if (opcode == OP_JAL)                       state_d = JAL;
        else if ((opcode == OP_RTYPE) && (funct == FN_JR)) state_d = JR;
        else                                             state_d = HANDOFF;
      end
      BRANCH, JUMP, JAL, JR: state_d = FETCH;
      HANDOFF: begin
        if (exec_done) state_d = FETCH;
      end
      default: begin
        state_d = RESET_ST;
        cnt_d   = '0;
      end
    endcase
  end

  assign ctrl_d = decode_ctrl(state_d, opcode);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_ST;
      cnt_q   <= '0;
      ctrl_q  <= decode_ctrl(RESET_ST, opcode);
`ifdef PC_SEQ_BRANCH_EXT_EN
      gt_q    <= 1'b0;
      lte_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
`ifdef PC_SEQ_BRANCH_EXT_EN
      gt_q    <= (state_d == BRANCH) && (opcode == OP_BGT);
      lte_q   <= (state_d == BRANCH) && (opcode == OP_BLE);
`endif
    end
  end

  assign mem_read     = ctrl_q.mem_read;
  assign ir_write     = ctrl_q.ir_write;
  assign pc_write     = ctrl_q.pc_write;
  assign eq_c         = ctrl_q.eq_c;
  assign ne_c         = ctrl_q.ne_c;
  assign pc_source    = ctrl_q.pc_source;
  assign alu_src_a    = ctrl_q.alu_src_a;
  assign alu_src_b    = ctrl_q.alu_src_b;
  assign alu_op       = ctrl_q.alu_op;
  assign aluout_write = ctrl_q.aluout_write;
  assign reg_write_ra = ctrl_q.reg_write_ra;
  assign sp_init      = ctrl_q.sp_init;
  assign exec_req     = ctrl_q.exec_req;

`ifdef PC_SEQ_BRANCH_EXT_EN
  assign gt_c  = gt_q;
  assign lte_c = lte_q;
`else
  assign gt_c  = 1'b0;
  assign lte_c = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: per-instruction expected output traces built from the instruction-class rules.
module tb_pc_seq_ctrl;
  localparam int W = 2;
`ifdef PC_SEQ_BRANCH_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct packed {
    logic       mem_read;
    logic       ir_write;
    logic       pc_write;
    logic       eq_c;
    logic       ne_c;
    logic       gt_c;
    logic       lte_c;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       aluout_write;
    logic       reg_write_ra;
    logic       sp_init;
    logic       exec_req;
  } outs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic exec_done = 1'b0;
  logic mem_read, ir_write, pc_write, eq_c, ne_c, gt_c, lte_c;
  logic [1:0] pc_source, alu_src_b;
  logic alu_src_a, aluout_write, reg_write_ra, sp_init, exec_req;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  pc_seq_ctrl #(.MEM_WAIT(W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .exec_done(exec_done),
    .mem_read(mem_read), .ir_write(ir_write), .pc_write(pc_write),
    .eq_c(eq_c), .ne_c(ne_c), .gt_c(gt_c), .lte_c(lte_c),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .aluout_write(aluout_write), .reg_write_ra(reg_write_ra), .sp_init(sp_init), .exec_req(exec_req)
  );

  outs_t obs;
  assign obs = {mem_read, ir_write, pc_write, eq_c, ne_c, gt_c, lte_c, pc_source,
                alu_src_a, alu_src_b, alu_op, aluout_write, reg_write_ra, sp_init, exec_req};

  int total = 0;
  int bad = 0;
  outs_t exp_q[$];
  int    mode_q[$];   // 0: exec_done free, 1: hold low (handoff), 2: raise (last handoff cycle)
  outs_t obs_q[$];
  outs_t rst_obs;
  outs_t sp_only;

  // Expected trace of one instruction, from fetch entry to the cycle before the next fetch.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int n);
    outs_t e;
    bit br;
    exp_q.delete();
    mode_q.delete();
    for (int i = 0; i < W; i++) begin
      e = '0; e.mem_read = 1'b1;
      exp_q.push_back(e); mode_q.push_back(0);
    end
    e = '0; e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 3'b001;
    exp_q.push_back(e); mode_q.push_back(0);
    e = '0; e.alu_src_b = 2'b11; e.alu_op = 3'b001; e.aluout_write = 1'b1;
    exp_q.push_back(e); mode_q.push_back(0);
    br = (op == 6'h04) || (op == 6'h05) || (EXT && ((op == 6'h06) || (op == 6'h07)));
    e = '0;
    if (br) begin
      e.alu_src_a = 1'b1; e.alu_op = 3'b010; e.pc_source = 2'b01;
      e.eq_c = (op == 6'h04); e.ne_c = (op == 6'h05);
      e.lte_c = (op == 6'h06); e.gt_c = (op == 6'h07);
      exp_q.push_back(e); mode_q.push_back(0);
    end else if (op == 6'h02) begin
      e.pc_write = 1'b1; e.pc_source = 2'b10;
      exp_q.push_back(e); mode_q.push_back(0);
    end else if (op == 6'h03) begin
      e.pc_write = 1'b1; e.pc_source = 2'b10; e.reg_write_ra = 1'b1;
      exp_q.push_back(e); mode_q.push_back(0);
    end else if (op == 6'h00 && fn == 6'h08) begin
      e.pc_write = 1'b1; e.pc_source = 2'b11;
      exp_q.push_back(e); mode_q.push_back(0);
    end else begin
      e.exec_req = 1'b1;
      for (int k = 1; k <= n; k++) begin
        exp_q.push_back(e); mode_q.push_back(k == n ? 2 : 1);
      end
    end
  endtask

  // Drives one instruction and records what the DUT shows each cycle; cut >= 0 asserts reset in that cycle.
  task automatic drive(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input int n, input int cut, input bit done_hi);
    build(op, fn, n);
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs_q.push_back(obs);
      if (i < W) opcode = 6'($urandom);
      else if (i == W) begin opcode = op; funct = fn; end
      case (mode_q[i])
        1:       exec_done = 1'b0;
        2:       exec_done = 1'b1;
        default: exec_done = done_hi ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      if (i == cut) begin
        reset = 1'b1;
        exec_done = 1'b0;
        break;
      end
    end
    if (cut >= 0) begin
      @(negedge clk);
      rst_obs = obs;
      reset = 1'b0;
    end
    $display("instr %s op=%02h funct=%02h n=%0d cycles=%0d reset_cut=%0d",
             name, op, fn, n, obs_q.size(), cut);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) @(negedge clk);
      else begin
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
      end
      total++;
      if (obs !== sp_only) begin
        bad++; $display("FAIL reset_out[%0d] got=%h want=%h", i, obs, sp_only);
      end
    end
  endtask

  task automatic test_branches;
    logic [5:0] op;
    for (int b = 4; b <= 7; b++) begin
      op = 6'(b);
      drive("branch", op, 6'($urandom), $urandom_range(1, 3), -1, 1'b0);
      for (int i = 0; i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL branch op=%02h cyc=%0d got=%h want=%h", op, i, obs_q[i], exp_q[i]);
        end
        total++;
        if ($countones({obs_q[i].eq_c, obs_q[i].ne_c, obs_q[i].gt_c, obs_q[i].lte_c}) > 1 ||
            (obs_q[i].pc_write && (obs_q[i].eq_c | obs_q[i].ne_c | obs_q[i].gt_c | obs_q[i].lte_c))) begin
          bad++; $display("FAIL branch_excl op=%02h cyc=%0d got sels=%b pc_write=%b want <=1 sel and no pc_write with sel",
                          op, i, {obs_q[i].eq_c, obs_q[i].ne_c, obs_q[i].gt_c, obs_q[i].lte_c}, obs_q[i].pc_write);
        end
      end
    end
  endtask

  task automatic test_jumps;
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    ops[0] = 6'h02; fns[0] = 6'h15;
    ops[1] = 6'h03; fns[1] = 6'h08;
    ops[2] = 6'h00; fns[2] = 6'h08;
    for (int j = 0; j < 3; j++) begin
      drive("jump", ops[j], fns[j], 1, -1, 1'b0);
      for (int i = 0; i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL jump op=%02h cyc=%0d got=%h want=%h", ops[j], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_handoff;
    int lens [2];
    lens[0] = 5; lens[1] = 1;
    for (int j = 0; j < 2; j++) begin
      // exec_done held high outside HANDOFF must not shorten anything
      drive("handoff", 6'h23, 6'h00, lens[j], -1, 1'b1);
      for (int i = 0; i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL handoff n=%0d cyc=%0d got=%h want=%h", lens[j], i, obs_q[i], exp_q[i]);
        end
      end
    end
    // next instruction must start with a fetch and exec_req already low
    drive("after_handoff", 6'h05, 6'h00, 1, -1, 1'b0);
    total++;
    if (obs_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL handoff_exit got=%h want=%h", obs_q[0], exp_q[0]);
    end
  endtask

  task automatic test_reset_mid_fetch;
    drive("reset_fetch", 6'h04, 6'h00, 1, 1, 1'b0);
    total++;
    if (rst_obs !== sp_only) begin
      bad++; $display("FAIL reset_mid_fetch got=%h want=%h", rst_obs, sp_only);
    end
    drive("post_reset", 6'h02, 6'h00, 1, -1, 1'b0);
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL refetch cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_handoff;
    drive("reset_handoff", 6'h2b, 6'h00, 6, W + 3, 1'b0);
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL pre_reset_handoff cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (rst_obs !== sp_only) begin
      bad++; $display("FAIL reset_mid_handoff got=%h want=%h", rst_obs, sp_only);
    end
    drive("post_reset", 6'h00, 6'h08, 1, -1, 1'b0);
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL refetch2 cyc=%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] op;
    logic [5:0] fn;
    int n;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       begin op = 6'($urandom_range(2, 7)); fn = 6'($urandom); end
        1:       begin op = 6'h00; fn = ($urandom_range(0, 1) == 0) ? 6'h08 : 6'($urandom); end
        default: begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      n = $urandom_range(1, 4);
      drive("random", op, fn, n, -1, 1'b0);
      for (int i = 0; i < obs_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL random op=%02h fn=%02h cyc=%0d got=%h want=%h", op, fn, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    sp_only = '0;
    sp_only.sp_init = 1'b1;
    test_reset;
    test_branches;
    test_jumps;
    test_handoff;
    test_reset_mid_fetch;
    test_reset_mid_handoff;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
